// File: rtl/mod503_horner_reducer.sv
// mod503_horner_reducer: streaming X mod 503 over 6-bit MSB-first chunks by Horner's rule
module mod503_horner_reducer (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [5:0] in_chunk,
   input  logic       in_last,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [8:0] out_residue,
   output logic       out_err
);
   localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2;
   localparam int NCHUNK = 34;
   logic [1:0] state;
   logic [8:0] acc, acc_n;
   logic [5:0] cnt, cnt_n, q;
   logic [14:0] t, r, rr;
   logic fin, ovf;
   assign in_ready = !rst && state != DONE;
   assign out_valid = state == DONE;
   // 65/32768 slightly underestimates 1/503, so q is short by at most one
   always_comb begin
      t = {acc, 6'b0} + {9'b0, in_chunk};
      q = 6'(({6'b0, t} * 21'd65) >> 15);
      r = t - 15'(q) * 15'd503;
      rr = r >= 15'd503 ? r - 15'd503 : r;
      acc_n = 9'(rr);
      cnt_n = cnt + 6'd1;
      ovf = !in_last && cnt_n == 6'(NCHUNK);
      fin = in_last || ovf;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc <= '0;
         cnt <= '0;
         out_residue <= '0;
         out_err <= 1'b0;
      end else if (state == DONE) begin
         if (out_ready) begin
            state <= IDLE;
            acc <= '0;
            cnt <= '0;
         end
      end else if (in_valid) begin
         acc <= acc_n;
         cnt <= cnt_n;
         state <= fin ? DONE : ACCUM;
         if (fin) begin
            out_residue <= acc_n;
            out_err <= ovf;
         end
      end
   end
endmodule

// File: tb/tb_mod503_horner_reducer.sv
// tb_mod503_horner_reducer: directed and randomised checks of the mod-503 Horner reducer
module tb_mod503_horner_reducer;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic [5:0] in_chunk = '0;
   logic in_ready, out_valid, out_err;
   logic [8:0] out_residue;
   int n_cmp = 0, n_fail = 0;

   mod503_horner_reducer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_chunk(in_chunk), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_residue(out_residue), .out_err(out_err)
   );

   always #5 clk = ~clk;

   task automatic push(input logic [5:0] c, input logic l);
      int g = 0;
      in_valid = 1'b1;
      in_chunk = c;
      in_last = l;
      #1;
      while (!in_ready && g < 200) begin
         @(negedge clk);
         #1;
         g++;
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL push_wait in_ready=%b required 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out();
      int g = 0;
      while (!out_valid && g < 200) begin
         @(negedge clk);
         g++;
      end
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL out_wait out_valid=%b required 1", out_valid);
      end
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if ({in_ready, out_valid, out_residue, out_err} !== 12'b0) begin
         n_fail++;
         $display("FAIL reset_state got rdy=%b vld=%b res=%0d err=%b required 0 0 0 0", in_ready, out_valid, out_residue, out_err);
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release got rdy=%b vld=%b required 1 0", in_ready, out_valid);
      end
      @(negedge clk);
   endtask

   task automatic test_single();
      push(6'h3F, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b1 || out_residue !== 9'd63 || out_err !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL single got vld=%b res=%0d err=%b rdy=%b required 1 63 0 0", out_valid, out_residue, out_err, in_ready);
      end
      pop();
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL single_idle got vld=%b rdy=%b required 0 1", out_valid, in_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_pairs();
      push(6'h3F, 1'b0);
      push(6'h3F, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b1 || out_residue !== 9'd71 || out_err !== 1'b0) begin
         n_fail++;
         $display("FAIL pair_4095 got vld=%b res=%0d err=%b required 1 71 0", out_valid, out_residue, out_err);
      end
      pop();
      push(6'd7, 1'b0);
      push(6'd55, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b1 || out_residue !== 9'd0 || out_err !== 1'b0) begin
         n_fail++;
         $display("FAIL pair_503 got vld=%b res=%0d err=%b required 1 0 0", out_valid, out_residue, out_err);
      end
      pop();
   endtask

   task automatic test_back_to_back();
      logic [5:0] v [4];
      v = '{6'd1, 6'd0, 6'd0, 6'd0};
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_chunk = v[i];
         in_last = i == 3;
         #1;
         n_cmp++;
         if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready chunk %0d in_ready=%b required 1", i, in_ready);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || out_residue !== 9'd81 || out_err !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b got vld=%b res=%0d err=%b required 1 81 0", out_valid, out_residue, out_err);
      end
      pop();
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 34; i++) push(6'd0, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b1 || out_residue !== 9'd0 || out_err !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_done got vld=%b res=%0d err=%b required 1 0 1", out_valid, out_residue, out_err);
      end
      in_valid = 1'b1;
      in_chunk = 6'd5;
      in_last = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_cmp++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_pending got rdy=%b vld=%b err=%b required 0 1 1", in_ready, out_valid, out_err);
         end
         @(negedge clk);
      end
      pop();
      #1;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_reopen got rdy=%b vld=%b required 1 0", in_ready, out_valid);
      end
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || out_residue !== 9'd5 || out_err !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_next got vld=%b res=%0d err=%b required 1 5 0", out_valid, out_residue, out_err);
      end
      pop();
   endtask

   task automatic test_backpressure();
      push(6'h3F, 1'b0);
      push(6'h3F, 1'b1);
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (out_valid !== 1'b1 || out_residue !== 9'd71 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold cycle %0d got vld=%b res=%0d rdy=%b required 1 71 0", i, out_valid, out_residue, in_ready);
         end
         @(negedge clk);
      end
      pop();
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release got vld=%b rdy=%b required 0 1", out_valid, in_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_mid_reset();
      push(6'h3F, 1'b0);
      push(6'h3F, 1'b0);
      rst = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset got rdy=%b vld=%b required 0 0", in_ready, out_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      push(6'd5, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b1 || out_residue !== 9'd5 || out_err !== 1'b0) begin
         n_fail++;
         $display("FAIL after_reset got vld=%b res=%0d err=%b required 1 5 0", out_valid, out_residue, out_err);
      end
      pop();
   endtask

   task automatic test_random();
      for (int n = 0; n < 1000; n++) begin
         int len = $urandom_range(1, 34);
         int m = 0;
         for (int i = 0; i < len; i++) begin
            logic [5:0] c = 6'($urandom_range(0, 63));
            repeat ($urandom_range(0, 1)) @(negedge clk);
            m = (m * 64 + int'(c)) % 503;
            push(c, i == len - 1);
         end
         wait_out();
         repeat ($urandom_range(0, 2)) @(negedge clk);
         n_cmp++;
         if (out_residue !== 9'(m) || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL random op %0d len %0d got res=%0d err=%b required %0d 0", n, len, out_residue, out_err, m);
         end
         pop();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_pairs();
      test_back_to_back();
      test_overflow();
      test_backpressure();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/mod503_horner_reducer.md
# mod503_horner_reducer

Sequential streaming reducer computing X mod 503 for a binary operand of up to 200 bits, delivered as 6-bit chunks MSB-first. Each accepted chunk updates the running residue by Horner's rule, r ← (r·64 + chunk) mod 503. It is the consuming end of the 6-bit-chunk / 9-bit-residue interface used by the mod-503 combinational LUT stages. Its results serve as the sequential golden reference for those stages.

## Interface
- MOD, 503, modulus; fixed; 2^9 > MOD > 2^8.
- RW, 9, residue width.
- CW, 6, chunk width.
- NCHUNK, 34, maximum chunks per operand (ceil(200/6); 204-bit capacity).

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  chunk present.
- in_ready  out  1  reducer can accept a chunk.
- in_chunk  in  6  operand chunk, MSB-first order.
- in_last  in  1  final chunk of the operand.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_residue  out  9  X mod 503, range 0..502.
- out_err  out  1  chunk-count overflow flag; qualified by out_valid.

## Operation
- Input accept = in_valid & in_ready. Output accept = out_valid & out_ready.
- States:
  - IDLE: acc=0, cnt=0, in_ready=1.
  - ACCUM: in_ready=1.
  - DONE: in_ready=0, out_valid=1.
- IDLE or ACCUM, on accept:
  - acc ← (acc·64 + in_chunk) mod 503; cnt ← cnt+1.
  - If in_last=1, or cnt reaches NCHUNK: go to DONE. Load out_residue with the new acc.
  - Otherwise go to (or stay in) ACCUM.
- Overflow: if the NCHUNK-th chunk is accepted with in_last=0, it is treated as last and out_err=1. Otherwise out_err=0.
- DONE: out_residue and out_err are held stable. On output accept go to IDLE, clear acc and cnt, and set out_valid=0.
- Input with in_valid=1 during DONE is not accepted; upstream must hold it.
- Arithmetic: intermediate t = acc·64 + chunk ≤ 502·64+63 = 32191, 15 bits unsigned. The reduction must be exact within one cycle: acc < 503 always. The implementation may estimate q = t/503 and apply up to two corrective subtractions.
- in_chunk and in_last are ignored when in_valid=0.
- Reset (any state, including mid-operand):
  - state=IDLE, acc=0, cnt=0.
  - out_valid=0, out_residue=0, out_err=0.
  - in_ready=0 while rst=1.
  - A partially accumulated operand is discarded.

## Timing
- in_ready = !rst & (state≠DONE). out_valid is registered.
- Throughput: one chunk per cycle while in_ready=1.
- Latency: out_valid rises on the edge after the cycle in which the last chunk is accepted.
- Inter-operand gap:
  - An output accept in cycle M yields in_ready=1 in cycle M+1.
  - A K-chunk operand therefore occupies K+1 cycles minimum, including the output cycle.
- out_valid and out_residue never change while out_valid=1 and out_ready=0.
- First cycle after rst deasserts: in_ready=1, out_valid=0.

## Test plan
- Single chunk 0x3F, last → out_residue=63, out_err=0. out_valid is high the cycle after acceptance.
- Chunks 0x3F,0x3F (X=4095), last on second → 71. Chunks 7,55 (X=503) → 0.
- Chunks 1,0,0,0 back-to-back, in_valid held high → 81. in_ready=1 throughout, so 4 accept cycles.
- 34 zero chunks with in_last=0 throughout:
  - DONE after the 34th chunk, out_residue=0, out_err=1.
  - The 35th chunk stays pending, in_ready=0.
  - It is accepted in the cycle after the output handshake.
- Backpressure: result 71 with out_ready=0 for 5 cycles.
  - out_valid=1 and 71 held for all 5 cycles; in_ready=0.
  - Handshake on the 6th cycle, IDLE the next cycle.
- Reset mid-operand:
  - Accept chunks 0x3F,0x3F, then rst=1 for 1 cycle: out_valid=0, in_ready=0 during reset.
  - Then single chunk 5, last → 5, with no residue carried over.
  - Randomised: 1000 operands of 1–34 chunks with random valid/ready stalls. Each result is compared against a big-integer mod-503 model.
